// File: rtl/spi_seq_arbiter.sv
// -----------------------------------------------------------------------------
// spi_seq_arbiter
//
// Arbitrates two transaction requesters onto the register port of an SPI
// master core and sequences each transaction through register accesses:
// slave select, SSO on, then per byte: wait TRDY, write TX, wait RRDY, read RX,
// and finally wait TMT, SSO off and a done pulse to the granted requester.
//
// Every core access occupies three cycles: one idle set-up cycle followed by
// two cycles with spi_select=1 and one strobe low. Read data is sampled on the
// edge that ends the second active cycle. A status wait that exceeds
// POLL_LIMIT completed reads flags err and jumps straight to SSO off.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   reqN_valid/ssel/len/wdata    request (N = 0,1), held until reqN_done
//   reqN_done/err/rdata          completion pulse, timeout flag, RX bytes
//   spi_select, write_n, read_n  core access control
//   mem_addr, data_from_cpu      core register address / write data
//   data_to_cpu                  core register read data
// -----------------------------------------------------------------------------
module spi_seq_arbiter #(
  parameter int POLL_LIMIT = 1023,
  parameter int NUM_SS     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [2:0]  req0_ssel,
  input  logic [1:0]  req0_len,
  input  logic [31:0] req0_wdata,
  output logic        req0_done,
  output logic        req0_err,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic [2:0]  req1_ssel,
  input  logic [1:0]  req1_len,
  input  logic [31:0] req1_wdata,
  output logic        req1_done,
  output logic        req1_err,
  output logic [31:0] req1_rdata,
  output logic        spi_select,
  output logic        write_n,
  output logic        read_n,
  output logic [2:0]  mem_addr,
  output logic [15:0] data_from_cpu,
  input  logic [15:0] data_to_cpu
);

  localparam int CNT_W = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT + 1);

  // Only slave-select bits that exist on the core may be driven.
  localparam logic [15:0] SS_MASK = (NUM_SS >= 16) ? 16'hFFFF :
                                    16'((32'd1 << NUM_SS) - 32'd1);

  localparam logic [2:0] ADDR_RX    = 3'd0;
  localparam logic [2:0] ADDR_TX    = 3'd1;
  localparam logic [2:0] ADDR_STAT  = 3'd2;
  localparam logic [2:0] ADDR_CTRL  = 3'd3;
  localparam logic [2:0] ADDR_SLAVE = 3'd5;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    SEL     = 4'd1,
    SSO_ON  = 4'd2,
    POLL_T  = 4'd3,
    WR_TX   = 4'd4,
    POLL_R  = 4'd5,
    RD_RX   = 4'd6,
    POLL_E  = 4'd7,
    SSO_OFF = 4'd8,
    DONE    = 4'd9
  } state_t;

  state_t             state_r;
  logic [1:0]         phase_r;     // 0: idle set-up, 1..2: active cycles
  logic               rr_ptr_r;    // requester favoured on a tie
  logic               grant_r;
  logic [2:0]         ssel_r;
  logic [1:0]         len_r;
  logic [1:0]         byte_idx_r;
  logic [31:0]        tx_sr_r;     // next TX byte always in [31:24]
  logic [31:0]        rx_acc_r;
  logic               err_r;
  logic [CNT_W-1:0]   poll_cnt_r;

  logic               gnt_valid_s;
  logic               gnt_sel_s;
  logic [2:0]         gnt_ssel_s;
  logic [1:0]         gnt_len_s;
  logic [31:0]        gnt_wdata_s;
  logic [4:0]         gnt_shift_s;
  logic [15:0]        sel_onehot_s;
  logic [2:0]         acc_addr_s;
  logic [15:0]        acc_wdata_s;
  logic               acc_write_s;
  logic [3:0]         wait_bit_s;
  logic               status_ok_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               poll_limit_s;

  // Round-robin grant: on a tie the pointer decides, otherwise the lone requester wins.
  assign gnt_valid_s = req0_valid | req1_valid;
  assign gnt_sel_s   = (req0_valid & req1_valid) ? rr_ptr_r : req1_valid;
  assign gnt_ssel_s  = gnt_sel_s ? req1_ssel  : req0_ssel;
  assign gnt_len_s   = gnt_sel_s ? req1_len   : req0_len;
  assign gnt_wdata_s = gnt_sel_s ? req1_wdata : req0_wdata;
  // Left-align the used bytes so the first byte to send sits in [31:24].
  assign gnt_shift_s = {2'd3 - gnt_len_s, 3'b000};

  assign sel_onehot_s = (16'h0001 << ssel_r) & SS_MASK;
  assign status_ok_s  = data_to_cpu[wait_bit_s];
  assign cnt_inc_s    = poll_cnt_r + CNT_W'(1);
  assign poll_limit_s = (cnt_inc_s == CNT_W'(POLL_LIMIT));

  // Decode the register access issued by the current state and the status bit it waits on.
  always_comb begin
    acc_addr_s  = ADDR_STAT;
    acc_wdata_s = 16'h0000;
    acc_write_s = 1'b0;
    wait_bit_s  = 4'd0;
    case (state_r)
      SEL: begin
        acc_addr_s  = ADDR_SLAVE;
        acc_wdata_s = sel_onehot_s;
        acc_write_s = 1'b1;
      end
      SSO_ON: begin
        acc_addr_s  = ADDR_CTRL;
        acc_wdata_s = 16'h0400;
        acc_write_s = 1'b1;
      end
      POLL_T: wait_bit_s = 4'd6;
      WR_TX: begin
        acc_addr_s  = ADDR_TX;
        acc_wdata_s = {8'h00, tx_sr_r[31:24]};
        acc_write_s = 1'b1;
      end
      POLL_R: wait_bit_s = 4'd7;
      RD_RX:  acc_addr_s = ADDR_RX;
      POLL_E: wait_bit_s = 4'd5;
      SSO_OFF: begin
        acc_addr_s  = ADDR_CTRL;
        acc_wdata_s = 16'h0000;
        acc_write_s = 1'b1;
      end
      default: begin
        acc_addr_s  = ADDR_STAT;
        acc_wdata_s = 16'h0000;
        acc_write_s = 1'b0;
        wait_bit_s  = 4'd0;
      end
    endcase
  end

  // Sequencer FSM: arbitration, per-access phasing, byte stepping, polling and completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      phase_r       <= 2'd0;
      rr_ptr_r      <= 1'b0;
      grant_r       <= 1'b0;
      ssel_r        <= 3'd0;
      len_r         <= 2'd0;
      byte_idx_r    <= 2'd0;
      tx_sr_r       <= 32'd0;
      rx_acc_r      <= 32'd0;
      err_r         <= 1'b0;
      poll_cnt_r    <= {CNT_W{1'b0}};
      spi_select    <= 1'b0;
      write_n       <= 1'b1;
      read_n        <= 1'b1;
      mem_addr      <= 3'd0;
      data_from_cpu <= 16'h0000;
      req0_done     <= 1'b0;
      req0_err      <= 1'b0;
      req0_rdata    <= 32'd0;
      req1_done     <= 1'b0;
      req1_err      <= 1'b0;
      req1_rdata    <= 32'd0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            grant_r    <= gnt_sel_s;
            rr_ptr_r   <= ~gnt_sel_s;
            ssel_r     <= gnt_ssel_s;
            len_r      <= gnt_len_s;
            tx_sr_r    <= gnt_wdata_s << gnt_shift_s;
            rx_acc_r   <= 32'd0;
            byte_idx_r <= 2'd0;
            err_r      <= 1'b0;
            phase_r    <= 2'd0;
            state_r    <= SEL;
          end
        end
        DONE: state_r <= IDLE;
        SEL, SSO_ON, POLL_T, WR_TX, POLL_R, RD_RX, POLL_E, SSO_OFF: begin
          case (phase_r)
            2'd0: begin
              // Launch the access; address and data stay put for both active cycles.
              spi_select    <= 1'b1;
              mem_addr      <= acc_addr_s;
              data_from_cpu <= acc_wdata_s;
              write_n       <= ~acc_write_s;
              read_n        <= acc_write_s;
              phase_r       <= 2'd1;
            end
            2'd1: phase_r <= 2'd2;
            default: begin
              // End of the second active cycle: release the bus, use read data, step.
              spi_select <= 1'b0;
              write_n    <= 1'b1;
              read_n     <= 1'b1;
              phase_r    <= 2'd0;
              case (state_r)
                SEL: state_r <= SSO_ON;
                SSO_ON: begin
                  poll_cnt_r <= {CNT_W{1'b0}};
                  state_r    <= POLL_T;
                end
                POLL_T, POLL_R, POLL_E: begin
                  poll_cnt_r <= cnt_inc_s;
                  if (status_ok_s) begin
                    if (state_r == POLL_T) begin
                      state_r <= WR_TX;
                    end else if (state_r == POLL_R) begin
                      state_r <= RD_RX;
                    end else begin
                      state_r <= SSO_OFF;
                    end
                  end else if (poll_limit_s) begin
                    err_r   <= 1'b1;
                    state_r <= SSO_OFF;
                  end else begin
                    state_r <= state_r;
                  end
                end
                WR_TX: begin
                  poll_cnt_r <= {CNT_W{1'b0}};
                  state_r    <= POLL_R;
                end
                RD_RX: begin
                  rx_acc_r   <= {rx_acc_r[23:0], data_to_cpu[7:0]};
                  poll_cnt_r <= {CNT_W{1'b0}};
                  if (byte_idx_r == len_r) begin
                    state_r <= POLL_E;
                  end else begin
                    byte_idx_r <= byte_idx_r + 2'd1;
                    tx_sr_r    <= {tx_sr_r[23:0], 8'h00};
                    state_r    <= POLL_T;
                  end
                end
                SSO_OFF: begin
                  state_r <= DONE;
                  if (grant_r) begin
                    req1_done  <= 1'b1;
                    req1_err   <= err_r;
                    req1_rdata <= rx_acc_r;
                  end else begin
                    req0_done  <= 1'b1;
                    req0_err   <= err_r;
                    req0_rdata <= rx_acc_r;
                  end
                end
                default: state_r <= IDLE;
              endcase
            end
          endcase
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_seq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_seq_arbiter
//
// Self-checking bench. A behavioural SPI core answers register accesses; a
// bus monitor checks access shape and compares every register write and every
// done against expectations queued when each request is issued.
// -----------------------------------------------------------------------------
module tb_spi_seq_arbiter;

  localparam int POLL_LIMIT = 4;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] rdata;
  } done_t;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_ssel, req1_ssel;
  logic [1:0]  req0_len, req1_len;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_done, req1_done;
  logic        req0_err, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic        spi_select, write_n, read_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;

  // core model state
  logic        trdy_en;
  int          rr_delay;
  logic [7:0]  rx_tab [4];
  logic        m_cnt;
  logic        tx_pending;
  int          pend_polls;
  logic [1:0]  rx_idx;
  logic        rrdy;

  // checking state
  int          n_checks = 0;
  int          n_errors = 0;
  int          stat_reads = 0;
  int          act_cnt = 0;
  logic [2:0]  cap_addr;
  logic [15:0] cap_data;
  logic        cap_wn, cap_rn;
  logic [18:0] exp_wr_q [$];
  done_t       exp_done_q [$];

  spi_seq_arbiter #(.POLL_LIMIT(POLL_LIMIT), .NUM_SS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ssel(req0_ssel), .req0_len(req0_len),
    .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_err(req0_err),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_ssel(req1_ssel), .req1_len(req1_len),
    .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_err(req1_err),
    .req1_rdata(req1_rdata),
    .spi_select(spi_select), .write_n(write_n), .read_n(read_n),
    .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: RRDY appears rr_delay status reads after a TX write, RX pops rx_tab.
  assign rrdy = tx_pending && (pend_polls >= rr_delay);
  assign data_to_cpu = (mem_addr == 3'd2) ? {8'hA5, rrdy, trdy_en && !tx_pending, !tx_pending, 5'b00000} :
                       (mem_addr == 3'd0) ? {8'h5A, rx_tab[rx_idx]} : 16'h0000;

  // Core model state updates on the edge that completes each access.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt      <= 1'b0;
      tx_pending <= 1'b0;
      pend_polls <= 0;
      rx_idx     <= 2'd0;
    end else if (spi_select) begin
      if (m_cnt) begin
        m_cnt <= 1'b0;
        if (!write_n) begin
          if (mem_addr == 3'd1) begin
            tx_pending <= 1'b1;
            pend_polls <= 0;
          end else if (mem_addr == 3'd5) begin
            rx_idx <= 2'd0;
          end
        end else if (!read_n) begin
          if (mem_addr == 3'd2 && tx_pending) begin
            pend_polls <= pend_polls + 1;
          end else if (mem_addr == 3'd0) begin
            tx_pending <= 1'b0;
            rx_idx     <= rx_idx + 2'd1;
          end
        end
      end else begin
        m_cnt <= 1'b1;
      end
    end else begin
      m_cnt <= 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Queue the expected writes and completion for a request, then drive it.
  task automatic issue(input logic id, input logic [2:0] ssel, input logic [1:0] len,
                       input logic [31:0] wdata, input logic tmo);
    done_t       d;
    logic [31:0] sh;
    logic [31:0] r;
    logic [15:0] onehot;
    onehot = 16'h0001 << ssel;
    exp_wr_q.push_back({3'd5, onehot});
    exp_wr_q.push_back({3'd3, 16'h0400});
    r = 32'd0;
    if (!tmo) begin
      for (int k = 0; k <= int'(len); k++) begin
        sh = wdata >> (8 * (int'(len) - k));
        exp_wr_q.push_back({3'd1, 8'h00, sh[7:0]});
        r = {r[23:0], rx_tab[k]};
      end
    end
    exp_wr_q.push_back({3'd3, 16'h0000});
    d.id = id;
    d.err = tmo;
    d.rdata = r;
    exp_done_q.push_back(d);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_ssel = ssel; req0_len = len; req0_wdata = wdata;
    end else begin
      req1_valid = 1'b1; req1_ssel = ssel; req1_len = len; req1_wdata = wdata;
    end
  endtask

  // Wait for n done pulses (bounded), then withdraw both requests.
  task automatic wait_done(input int n);
    int seen;
    seen = 0;
    for (int cyc = 0; cyc < 4000 && seen < n; cyc++) begin
      @(negedge clk);
      if (req0_done || req1_done) seen++;
    end
    check_val("done_wait", seen, n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_spi_select", {31'd0, spi_select}, 32'd0);
    check_val("rst_write_n", {31'd0, write_n}, 32'd1);
    check_val("rst_read_n", {31'd0, read_n}, 32'd1);
    check_val("rst_mem_addr", {29'd0, mem_addr}, 32'd0);
    check_val("rst_data", {16'd0, data_from_cpu}, 32'd0);
    check_val("rst_done", {30'd0, req1_done, req0_done}, 32'd0);
    check_val("rst_err", {30'd0, req1_err, req0_err}, 32'd0);
    check_val("rst_rdata0", req0_rdata, 32'd0);
    check_val("rst_rdata1", req1_rdata, 32'd0);
  endtask

  // Bus monitor: access shape, write scoreboard, status-read count, done scoreboard.
  initial begin : monitor
    done_t       d;
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        act_cnt = 0;
        exp_wr_q.delete();
        exp_done_q.delete();
      end else begin
        if (spi_select) begin
          if (act_cnt == 0) begin
            cap_addr = mem_addr; cap_data = data_from_cpu;
            cap_wn = write_n; cap_rn = read_n;
            check_val("strobe_onehot", {31'd0, write_n ^ read_n}, 32'd1);
          end else begin
            check_val("addr_stable", {29'd0, mem_addr}, {29'd0, cap_addr});
            check_val("data_stable", {16'd0, data_from_cpu}, {16'd0, cap_data});
            check_val("strobe_stable", {30'd0, write_n, read_n}, {30'd0, cap_wn, cap_rn});
          end
          act_cnt++;
        end else if (act_cnt != 0) begin
          check_val("access_len", act_cnt, 2);
          check_val("idle_strobes", {30'd0, write_n, read_n}, 32'd3);
          if (!cap_wn) begin
            if (exp_wr_q.size() == 0) begin
              check_val("wr_pending", exp_wr_q.size(), 1);
            end else begin
              e = exp_wr_q.pop_front();
              check_val("wr_access", {13'd0, cap_addr, cap_data}, {13'd0, e});
            end
          end else if (cap_addr == 3'd2) begin
            stat_reads++;
          end
          act_cnt = 0;
        end
        if (req0_done || req1_done) begin
          if (exp_done_q.size() == 0) begin
            check_val("done_unexpected", {30'd0, req1_done, req0_done}, 32'd0);
          end else begin
            d = exp_done_q.pop_front();
            check_val("done_id", {30'd0, req1_done, req0_done}, d.id ? 32'd2 : 32'd1);
            check_val("rdata", d.id ? req1_rdata : req0_rdata, d.rdata);
            check_val("err", {31'd0, d.id ? req1_err : req0_err}, {31'd0, d.err});
          end
        end
      end
    end
  end

  initial begin : stim
    int base;
    int found;
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_ssel = 3'd0; req0_len = 2'd0; req0_wdata = 32'd0;
    req1_valid = 1'b0; req1_ssel = 3'd0; req1_len = 2'd0; req1_wdata = 32'd0;
    trdy_en = 1'b1;
    rr_delay = 1;
    rx_tab[0] = 8'h3C; rx_tab[1] = 8'h00; rx_tab[2] = 8'h00; rx_tab[3] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;
    @(negedge clk);

    // Single byte, echo 0x3C.
    issue(1'b0, 3'd2, 2'd0, 32'h000000A5, 1'b0);
    wait_done(1);

    // Four bytes on req1; req1 drops valid mid-way and req0 arrives mid-way.
    rx_tab[0] = 8'hA0; rx_tab[1] = 8'hA1; rx_tab[2] = 8'hA2; rx_tab[3] = 8'hA3;
    @(negedge clk);
    issue(1'b1, 3'd4, 2'd3, 32'h11223344, 1'b0);
    repeat (5) @(negedge clk);
    req1_valid = 1'b0;
    issue(1'b0, 3'd3, 2'd0, 32'h00000099, 1'b0);
    wait_done(2);

    // Simultaneous requests from reset, both held: grants 0, 1, 0.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 3'd1, 2'd0, 32'h00000055, 1'b0);
    issue(1'b1, 3'd6, 2'd1, 32'h0000BEEF, 1'b0);
    issue(1'b0, 3'd1, 2'd0, 32'h00000055, 1'b0);
    wait_done(3);

    // TRDY never set: exactly POLL_LIMIT status reads then abort.
    @(negedge clk);
    trdy_en = 1'b0;
    base = stat_reads;
    issue(1'b0, 3'd0, 2'd0, 32'h00000077, 1'b1);
    wait_done(1);
    @(negedge clk);
    check_val("timeout_reads", stat_reads - base, POLL_LIMIT);
    trdy_en = 1'b1;

    // Reset in POLL_R abandons the transaction.
    rr_delay = 100;
    issue(1'b1, 3'd5, 2'd0, 32'h00000042, 1'b0);
    found = 0;
    for (int cyc = 0; cyc < 200 && found == 0; cyc++) begin
      @(negedge clk);
      if (spi_select && !write_n && mem_addr == 3'd1) found = 1;
    end
    check_val("wrtx_seen", found, 1);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    req1_valid = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rr_delay = 1;
    repeat (20) @(negedge clk);

    // A fresh request after the reset completes normally.
    issue(1'b1, 3'd5, 2'd0, 32'h00000042, 1'b0);
    wait_done(1);
    repeat (5) @(negedge clk);
    check_val("wr_queue_empty", exp_wr_q.size(), 0);
    check_val("done_queue_empty", exp_done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_seq_arbiter.md
SPI_SEQ_ARBITER -- requirements
Module: spi_seq_arbiter

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 1023: maximum status polls per wait before abort.
REQ-002 SHALL have parameter NUM_SS, default 8: number of slave-select bits on the SPI core.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports reqN_valid  in  1, for N=0,1  transaction request, held until reqN_done.
REQ-006 SHALL have ports reqN_ssel  in  3  target slave index; reqN_len  in  2  byte count minus 1; reqN_wdata  in  32  TX bytes, MSB byte first.
REQ-007 SHALL have ports reqN_done  out  1  one-cycle completion pulse; reqN_err  out  1  timeout flag, valid with done; reqN_rdata  out  32  RX bytes, valid with done.
REQ-008 SHALL have ports spi_select, write_n, read_n  out  1 each; mem_addr  out  3; data_from_cpu  out  16; data_to_cpu  in  16. These drive the SPI core register port: 0 rx, 1 tx, 2 status, 3 control, 5 slave-enable.

Function
REQ-009 SHALL perform every core access as exactly 2 cycles with spi_select=1, the strobe low, and mem_addr and data_from_cpu held stable.
REQ-010 SHALL follow every access with at least 1 idle cycle: spi_select=0, write_n=1, read_n=1.
REQ-011 SHALL sample data_to_cpu for a read on the rising edge that ends the access's second cycle.
REQ-012 SHALL use states IDLE, SEL, SSO_ON, POLL_T, WR_TX, POLL_R, RD_RX, POLL_E, SSO_OFF, DONE.
REQ-013 IDLE: with any valid, SHALL grant round-robin; the pointer favours the requester not granted last; reset pointer favours req0. SHALL latch ssel, len and wdata, then go to SEL.
REQ-014 SEL: SHALL write addr 5 with one-hot (1<<ssel) zero-extended to 16 bits. SSO_ON: SHALL write addr 3 with 0x0400 (SSO set, interrupts off).
REQ-015 POLL_T: SHALL read addr 2 until bit6 (TRDY)=1. WR_TX: SHALL write addr 1 with the current byte in [7:0] and [15:8]=0.
REQ-016 POLL_R: SHALL read addr 2 until bit7 (RRDY)=1. RD_RX: SHALL read addr 0 and shift data_to_cpu[7:0] into the rdata LSB.
REQ-017 After RD_RX: if bytes sent < len+1, SHALL return to POLL_T with the next wdata byte; otherwise SHALL go to POLL_E.
REQ-018 POLL_E: SHALL read addr 2 until bit5 (TMT)=1. SSO_OFF: SHALL write addr 3 with 0x0000. DONE: SHALL pulse reqN_done for 1 cycle, then return to IDLE.
REQ-019 Byte order: wdata byte (len-k) SHALL be sent at step k, for k = 0..len. rdata SHALL be right-aligned; unused upper bytes SHALL be 0.
REQ-020 SHALL count each completed status read in a poll counter that clears on entry to each POLL state.
REQ-021 When the counter reaches POLL_LIMIT without the awaited bit, SHALL set err and go straight to SSO_OFF. done then SHALL carry err=1, with rdata holding the bytes received so far.
REQ-022 A request arriving from the other requester mid-transaction SHALL wait; there is no preemption.
REQ-023 If the granted requester deasserts valid mid-transaction, the sequence SHALL complete and done SHALL still pulse.
REQ-024 reqN_rdata and reqN_err SHALL hold their values until that requester's next done.

Reset
REQ-025 While reset_n=0: state=IDLE, spi_select=0, write_n=1, read_n=1, mem_addr=0, data_from_cpu=0, all done/err/rdata=0, RR pointer=req0, poll counter=0.
REQ-026 Reset asserted mid-transaction SHALL abandon it immediately, with no SSO_OFF write and no done pulse.

Verification
REQ-027 req0 ssel=2, len=0, wdata=0x000000A5, core model echoing MISO=0x3C -> writes 5:0x0004, 3:0x0400, 1:0x00A5, 3:0x0000; done0 with rdata=0x0000003C, err=0.
REQ-028 req1 len=3, wdata=0x11223344 -> tx order 0x11, 0x22, 0x33, 0x44; rx bytes 0xA0..0xA3 give rdata=0xA0A1A2A3.
REQ-029 req0 and req1 valid in the same cycle from reset -> req0 served first, then req1. Both held valid -> grants alternate 0, 1, 0.
REQ-030 Core model never sets TRDY, POLL_LIMIT=4 -> exactly 4 status reads, then a 3:0x0000 write, done with err=1.
REQ-031 Every access checked: strobe low for exactly 2 cycles with addr/data stable, followed by at least 1 idle cycle.
REQ-032 reset_n pulsed low during POLL_R -> all outputs return to reset values at once and no done pulse occurs. A new request afterwards completes normally.
